// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and LC-3 KBSR bit positions.
// Also imported by the transmitter side of the UART.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_RX_START_BIT = 3'd1,
        s_RX_DATA_BITS = 3'd2,
        s_RX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4
    } rx_state_t;

    localparam int KBSR_READY_BIT   = 15;
    localparam int KBSR_OVERRUN_BIT = 14;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to
// the idle-high level so reset never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_kbd.sv
// 8N1 UART receiver feeding the LC-3 keyboard registers KBSR/KBDR.
// Define UART_RX_OVERRUN_EN to get the sticky overrun flag in KBSR[14].
module uart_rx_kbd
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 870
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_Serial,
    input  logic        i_KBDR_Rd,
    output logic        o_Rx_DV,
    output logic [7:0]  o_Rx_Byte,
    output logic        o_Rx_Err,
    output logic        o_Rx_Active,
    output logic [15:0] o_KBSR,
    output logic [15:0] o_KBDR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    rx_state_t     state_q, state_d;
    logic          rx;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          brk;
    logic          ready;
    logic          ovr;
    logic          cnt_clr, bit_take, stop_ok, stop_bad;

    sync_2ff u_sync (
        .clk (i_Clock),
        .rst (i_Reset),
        .d   (i_Rx_Serial),
        .q   (rx)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state_q <= s_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        bit_take = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            s_IDLE: begin
                cnt_clr = 1'b1;
                // After a framing error the line must return high first (break).
                if (!rx && !brk) state_d = s_RX_START_BIT;
            end
            s_RX_START_BIT: begin
                if (cnt == HALF) begin
                    cnt_clr = 1'b1;
                    state_d = rx ? s_IDLE : s_RX_DATA_BITS;
                end
            end
            s_RX_DATA_BITS: begin
                if (cnt == LAST) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (idx == 3'd7) state_d = s_RX_STOP_BIT;
                end
            end
            s_RX_STOP_BIT: begin
                if (cnt == LAST) begin
                    cnt_clr  = 1'b1;
                    stop_ok  = rx;
                    stop_bad = !rx;
                    state_d  = s_CLEANUP;
                end
            end
            s_CLEANUP: begin
                cnt_clr = 1'b1;
                state_d = s_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = s_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            brk       <= 1'b0;
            o_Rx_DV   <= 1'b0;
            o_Rx_Err  <= 1'b0;
            o_Rx_Byte <= 8'h00;
        end else begin
            cnt      <= cnt_clr ? '0 : cnt + 1'b1;
            o_Rx_DV  <= stop_ok;
            o_Rx_Err <= stop_bad;
            if (state_q == s_IDLE) idx <= '0;
            else if (bit_take)     idx <= idx + 1'b1;
            if (bit_take) shift[idx] <= rx;
            if (stop_ok)  o_Rx_Byte  <= shift;
            if (stop_bad) brk <= 1'b1;
            else if (rx)  brk <= 1'b0;
        end
    end

    // Ready follows the DV pulse, so a read landing on the DV cycle loses to the set.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)        ready <= 1'b0;
        else if (o_Rx_DV)   ready <= 1'b1;
        else if (i_KBDR_Rd) ready <= 1'b0;
    end

`ifdef UART_RX_OVERRUN_EN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                 ovr <= 1'b0;
        else if (i_KBDR_Rd)          ovr <= 1'b0;
        else if (o_Rx_DV && ready)   ovr <= 1'b1;
    end
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        o_KBSR                   = 16'h0000;
        o_KBSR[KBSR_READY_BIT]   = ready;
        o_KBSR[KBSR_OVERRUN_BIT] = ovr;
    end

    assign o_KBDR      = {8'h00, o_Rx_Byte};
    assign o_Rx_Active = (state_q == s_RX_START_BIT) || (state_q == s_RX_DATA_BITS) ||
                         (state_q == s_RX_STOP_BIT);

endmodule

// File: tb/tb_uart_rx_kbd.sv
// Directed bench for uart_rx_kbd at 16 clocks per bit; stimulus driven and
// outputs sampled on the falling clock edge.
module tb_uart_rx_kbd;

    localparam int BT = 16;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b0;
    logic        i_Rx_Serial = 1'b1;
    logic        i_KBDR_Rd = 1'b0;
    logic        o_Rx_DV;
    logic [7:0]  o_Rx_Byte;
    logic        o_Rx_Err;
    logic        o_Rx_Active;
    logic [15:0] o_KBSR;
    logic [15:0] o_KBDR;

    int total = 0;
    int bad   = 0;
    int dv_cnt = 0;
    int err_cnt = 0;

    uart_rx_kbd #(.CLKS_PER_BIT(BT)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .i_KBDR_Rd   (i_KBDR_Rd),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Rx_Err    (o_Rx_Err),
        .o_Rx_Active (o_Rx_Active),
        .o_KBSR      (o_KBSR),
        .o_KBDR      (o_KBDR)
    );

    always #5 i_Clock = ~i_Clock;

    // Counts high cycles, so a stretched pulse shows up as a count above one.
    always @(negedge i_Clock) begin
        if (o_Rx_DV)  dv_cnt  = dv_cnt + 1;
        if (o_Rx_Err) err_cnt = err_cnt + 1;
    end

`ifdef UART_RX_OVERRUN_EN
    localparam logic [15:0] KBSR_TWO = 16'hC000;
`else
    localparam logic [15:0] KBSR_TWO = 16'h8000;
`endif

    task automatic clks(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        i_Rx_Serial = 1'b0;
        clks(BT);
        for (int i = 0; i < 8; i++) begin
            i_Rx_Serial = b[i];
            clks(BT);
        end
        i_Rx_Serial = stop;
        clks(BT);
        i_Rx_Serial = 1'b1;
        clks(20);
    endtask

    task automatic kbdr_read();
        i_KBDR_Rd = 1'b1;
        clks(1);
        i_KBDR_Rd = 1'b0;
        clks(2);
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        clks(3);
        total++;
        if ({o_Rx_DV, o_Rx_Err, o_Rx_Active} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {o_Rx_DV, o_Rx_Err, o_Rx_Active});
        end
        total++;
        if ({o_Rx_Byte, o_KBSR, o_KBDR} !== 40'h0) begin
            bad++; $display("FAIL reset_regs byte=%h kbsr=%h kbdr=%h exp=0", o_Rx_Byte, o_KBSR, o_KBDR);
        end
        i_Reset = 1'b0;
        clks(5);
    endtask

    task automatic test_basic();
        dv_cnt = 0; err_cnt = 0;
        send_frame(8'h41, 1'b1);
        total++;
        if (dv_cnt !== 1 || err_cnt !== 0) begin
            bad++; $display("FAIL basic_pulses dv=%0d err=%0d exp dv=1 err=0", dv_cnt, err_cnt);
        end
        total++;
        if (o_KBDR !== 16'h0041 || o_Rx_Byte !== 8'h41) begin
            bad++; $display("FAIL basic_kbdr got=%h byte=%h exp=0041", o_KBDR, o_Rx_Byte);
        end
        total++;
        if (o_KBSR !== 16'h8000) begin
            bad++; $display("FAIL basic_kbsr got=%h exp=8000", o_KBSR);
        end
        kbdr_read();
        total++;
        if (o_KBSR !== 16'h0000 || o_KBDR !== 16'h0041) begin
            bad++; $display("FAIL basic_read kbsr=%h kbdr=%h exp 0000/0041", o_KBSR, o_KBDR);
        end
    endtask

    task automatic test_glitch();
        dv_cnt = 0; err_cnt = 0;
        i_Rx_Serial = 1'b0;
        clks(4);
        total++;
        if (o_Rx_Active !== 1'b1) begin
            bad++; $display("FAIL glitch_active_start got=%b exp=1", o_Rx_Active);
        end
        clks(1);
        i_Rx_Serial = 1'b1;
        clks(30);
        total++;
        if (dv_cnt !== 0 || err_cnt !== 0 || o_Rx_Active !== 1'b0) begin
            bad++; $display("FAIL glitch dv=%0d err=%0d active=%b exp 0/0/0", dv_cnt, err_cnt, o_Rx_Active);
        end
        total++;
        if (o_KBSR !== 16'h0000 || o_KBDR !== 16'h0041) begin
            bad++; $display("FAIL glitch_regs kbsr=%h kbdr=%h exp 0000/0041", o_KBSR, o_KBDR);
        end
    endtask

    task automatic test_frame_err();
        dv_cnt = 0; err_cnt = 0;
        send_frame(8'hA5, 1'b0);
        total++;
        if (err_cnt !== 1 || dv_cnt !== 0) begin
            bad++; $display("FAIL ferr_pulses err=%0d dv=%0d exp err=1 dv=0", err_cnt, dv_cnt);
        end
        total++;
        if (o_KBDR !== 16'h0041 || o_KBSR !== 16'h0000) begin
            bad++; $display("FAIL ferr_regs kbdr=%h kbsr=%h exp 0041/0000", o_KBDR, o_KBSR);
        end
    endtask

    task automatic test_break();
        dv_cnt = 0; err_cnt = 0;
        i_Rx_Serial = 1'b0;
        clks(400);
        total++;
        if (err_cnt !== 1 || dv_cnt !== 0 || o_Rx_Active !== 1'b0) begin
            bad++; $display("FAIL break err=%0d dv=%0d active=%b exp 1/0/0", err_cnt, dv_cnt, o_Rx_Active);
        end
        i_Rx_Serial = 1'b1;
        clks(20);
    endtask

    task automatic test_back_to_back();
        dv_cnt = 0; err_cnt = 0;
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        total++;
        if (dv_cnt !== 2 || err_cnt !== 0) begin
            bad++; $display("FAIL b2b_pulses dv=%0d err=%0d exp 2/0", dv_cnt, err_cnt);
        end
        total++;
        if (o_KBDR !== 16'h0032) begin
            bad++; $display("FAIL b2b_kbdr got=%h exp=0032", o_KBDR);
        end
        total++;
        if (o_KBSR !== KBSR_TWO) begin
            bad++; $display("FAIL b2b_kbsr got=%h exp=%h", o_KBSR, KBSR_TWO);
        end
        kbdr_read();
        total++;
        if (o_KBSR !== 16'h0000) begin
            bad++; $display("FAIL b2b_read kbsr=%h exp=0000", o_KBSR);
        end
    endtask

    task automatic test_rd_coincide();
        int n;
        bit timeout;
        dv_cnt = 0; err_cnt = 0;
        n = 0;
        timeout = 0;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                while (!o_Rx_DV && n < 400) begin
                    @(negedge i_Clock);
                    n++;
                end
                if (n >= 400) timeout = 1;
                else begin
                    i_KBDR_Rd = 1'b1;
                    @(negedge i_Clock);
                    i_KBDR_Rd = 1'b0;
                end
            end
        join
        total++;
        if (timeout) begin
            bad++; $display("FAIL coincide_dv_wait got=timeout exp=dv pulse");
        end
        total++;
        if (o_KBSR !== 16'h8000 || o_KBDR !== 16'h007E) begin
            bad++; $display("FAIL coincide kbsr=%h kbdr=%h exp 8000/007e", o_KBSR, o_KBDR);
        end
        kbdr_read();
    endtask

    task automatic test_reset_midframe();
        dv_cnt = 0; err_cnt = 0;
        i_Rx_Serial = 1'b0;
        clks(BT);
        i_Rx_Serial = 1'b1;
        clks(4 * BT + BT / 2);
        i_Reset = 1'b1;
        clks(3);
        total++;
        if ({o_Rx_DV, o_Rx_Err, o_Rx_Active} !== 3'b000 || {o_Rx_Byte, o_KBSR, o_KBDR} !== 40'h0) begin
            bad++; $display("FAIL midreset_regs act=%b byte=%h kbsr=%h kbdr=%h exp all 0",
                            o_Rx_Active, o_Rx_Byte, o_KBSR, o_KBDR);
        end
        i_Reset = 1'b0;
        clks(8 * BT);
        total++;
        if (dv_cnt !== 0 || err_cnt !== 0 || o_Rx_Active !== 1'b0) begin
            bad++; $display("FAIL midreset_quiet dv=%0d err=%0d act=%b exp 0/0/0", dv_cnt, err_cnt, o_Rx_Active);
        end
        send_frame(8'h12, 1'b1);
        total++;
        if (dv_cnt !== 1 || o_KBDR !== 16'h0012 || o_KBSR !== 16'h8000) begin
            bad++; $display("FAIL midreset_next dv=%0d kbdr=%h kbsr=%h exp 1/0012/8000", dv_cnt, o_KBDR, o_KBSR);
        end
    endtask

    initial begin
        clks(2);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_rd_coincide();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
